// File: rtl/uart_frame_packer_if.sv
// Sample push port and paced byte output of the UART frame packer.
`timescale 1ns/1ps
interface uart_frame_packer_if;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  tx_data;
    logic        tx_flag;
    logic        busy;
    logic        overflow;

    modport master (
        output sample_data, sample_valid,
        input  sample_ready, tx_data, tx_flag, busy, overflow
    );

    modport slave (
        input  sample_data, sample_valid,
        output sample_ready, tx_data, tx_flag, busy, overflow
    );
endinterface

// File: rtl/uart_frame_packer.sv
// Buffers 16-bit samples and emits framed, byte-time-paced strobes to a UART transmitter.
// Optional trailing checksum byte: define UART_FRAME_CKSUM_EN.
`timescale 1ns/1ps
module uart_frame_packer #(
    parameter int          UART_BPS          = 9600,
    parameter int          CLK_FREQ          = 50_000_000,
    parameter int          SAMPLES_PER_FRAME = 4,
    parameter int          FIFO_DEPTH        = 16,
    parameter logic [7:0]  HDR0              = 8'hAA,
    parameter logic [7:0]  HDR1              = 8'h55
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    uart_frame_packer_if.slave bus
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int BYTE_GAP = 11 * BAUD_CNT;
    localparam int GAP_W    = $clog2(BYTE_GAP);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
`ifdef UART_FRAME_CKSUM_EN
    localparam int LAST_SEL = 2 * SAMPLES_PER_FRAME + 2;
`else
    localparam int LAST_SEL = 2 * SAMPLES_PER_FRAME + 1;
`endif
    localparam int SEL_W    = $clog2(LAST_SEL + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} state_t;

    // Sample FIFO
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_ok, pop;
    logic [15:0]      head;

    // Framing state
    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic             tx_flag_reg, tx_flag_next;
    logic             busy_reg, busy_next;
    logic             overflow_reg;
    logic [7:0]       byte_sel;
    logic             is_payload;
`ifdef UART_FRAME_CKSUM_EN
    logic [7:0]       cksum_reg, cksum_next;
`endif

    assign head             = mem[rd_ptr_reg];
    assign bus.sample_ready = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push_ok          = bus.sample_valid && bus.sample_ready;

`ifdef UART_FRAME_CKSUM_EN
    assign is_payload = (sel_reg >= SEL_W'(2)) && (sel_reg != SEL_W'(LAST_SEL));
`else
    assign is_payload = (sel_reg >= SEL_W'(2));
`endif

    // Payload starts at index 2, so even indices are MSB bytes and odd indices LSB bytes.
    assign pop = (state_reg == ST_EMIT) && is_payload && sel_reg[0];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= bus.sample_data;
    end

    always_comb begin
        byte_sel = sel_reg[0] ? head[7:0] : head[15:8];
        if (sel_reg == SEL_W'(0))
            byte_sel = HDR0;
        else if (sel_reg == SEL_W'(1))
            byte_sel = HDR1;
`ifdef UART_FRAME_CKSUM_EN
        else if (sel_reg == SEL_W'(LAST_SEL))
            byte_sel = cksum_reg;
`endif
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        gap_next     = gap_reg;
        tx_data_next = tx_data_reg;
        tx_flag_next = 1'b0;
        busy_next    = busy_reg;
`ifdef UART_FRAME_CKSUM_EN
        cksum_next   = cksum_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Wait for a whole frame of samples so a frame never stalls mid-way.
                if (count_reg >= CNT_W'(SAMPLES_PER_FRAME)) begin
                    state_next = ST_EMIT;
                    sel_next   = '0;
                    busy_next  = 1'b1;
`ifdef UART_FRAME_CKSUM_EN
                    cksum_next = '0;
`endif
                end
            end
            ST_EMIT: begin
                tx_flag_next = 1'b1;
                tx_data_next = byte_sel;
                gap_next     = GAP_W'(BYTE_GAP - 1);
                state_next   = ST_GAP;
`ifdef UART_FRAME_CKSUM_EN
                if (is_payload)
                    cksum_next = cksum_reg + byte_sel;
`endif
            end
            ST_GAP: begin
                // The EMIT cycle is the first clock of the byte time, so leave on the
                // decrement that reaches zero to keep strobes exactly BYTE_GAP apart.
                gap_next = gap_reg - GAP_W'(1);
                if (gap_reg == GAP_W'(1)) begin
                    if (sel_reg == SEL_W'(LAST_SEL)) begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                    end else begin
                        sel_next   = sel_reg + SEL_W'(1);
                        state_next = ST_EMIT;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= ST_IDLE;
            sel_reg      <= '0;
            gap_reg      <= '0;
            tx_data_reg  <= '0;
            tx_flag_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
            cksum_reg    <= '0;
`endif
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg    <= count_next;
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            gap_reg      <= gap_next;
            tx_data_reg  <= tx_data_next;
            tx_flag_reg  <= tx_flag_next;
            busy_reg     <= busy_next;
            overflow_reg <= bus.sample_valid && !bus.sample_ready;
`ifdef UART_FRAME_CKSUM_EN
            cksum_reg    <= cksum_next;
`endif
        end
    end

    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_flag  = tx_flag_reg;
    assign bus.busy     = busy_reg;
    assign bus.overflow = overflow_reg;
endmodule
